// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - datapath-facing strobe and status bundle for control_sequencer
interface control_sequencer_if;
    logic [31:0] IR;
    logic        CONFF;
    logic        Run;
    logic        PCout;
    logic        Zlowout;
    logic        MDRout;
    logic        Rout;
    logic        BAout;
    logic        Csignout;
    logic        PCin;
    logic        MARin;
    logic        MDRin;
    logic        IRin;
    logic        Yin;
    logic        Zlowin;
    logic        Rin;
    logic        CONin;
    logic        IncPC;
    logic        ADD;
    logic        BRANCH;
    logic        Read;
    logic        MD_read;
    logic        Write;
    logic        Gra;
    logic        Grb;

    modport master (
        input  IR, CONFF,
        output Run, PCout, Zlowout, MDRout, Rout, BAout, Csignout,
        output PCin, MARin, MDRin, IRin, Yin, Zlowin, Rin, CONin,
        output IncPC, ADD, BRANCH, Read, MD_read, Write, Gra, Grb
    );

    modport slave (
        output IR, CONFF,
        input  Run, PCout, Zlowout, MDRout, Rout, BAout, Csignout,
        input  PCin, MARin, MDRin, IRin, Yin, Zlowin, Rin, CONin,
        input  IncPC, ADD, BRANCH, Read, MD_read, Write, Gra, Grb
    );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired Moore control unit for the one-bus datapath
module control_sequencer #(
    parameter logic [4:0] OP_LDI  = 5'b00001,
    parameter logic [4:0] OP_ADDI = 5'b01100,
    parameter logic [4:0] OP_BR   = 5'b10010,
    parameter logic [4:0] OP_NOP  = 5'b11001,
    parameter logic [4:0] OP_HALT = 5'b11010
) (
    input  logic                  clock,
    input  logic                  clear,
    control_sequencer_if.master   bus
);

    typedef enum logic [3:0] {
        S_RESET, S_F0, S_F1, S_F2, S_DEC,
        S_A0, S_A1, S_A2,
        S_B0, S_B1, S_B2, S_B3,
        S_HALT
    } state_t;

    typedef struct packed {
        logic run;
        logic pc_out;
        logic zlow_out;
        logic mdr_out;
        logic r_out;
        logic ba_out;
        logic csign_out;
        logic pc_in;
        logic pc_in_cond;
        logic mar_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic zlow_in;
        logic r_in;
        logic con_in;
        logic inc_pc;
        logic add;
        logic branch;
        logic read;
        logic md_read;
        logic gra;
        logic grb;
    } ctl_t;

    state_t state;
    state_t state_n;
    ctl_t   ctl;
    logic   unused_ir;

    assign unused_ir = ^bus.IR[26:0];

    function automatic ctl_t decode(input state_t s);
        ctl_t c;
        c     = '0;
        c.run = 1'b1;
        case (s)
            S_F0: begin
                c.pc_out  = 1'b1;
                c.mar_in  = 1'b1;
                c.inc_pc  = 1'b1;
                c.zlow_in = 1'b1;
            end
            S_F1: begin
                c.zlow_out = 1'b1;
                c.pc_in    = 1'b1;
                c.read     = 1'b1;
                c.md_read  = 1'b1;
                c.mdr_in   = 1'b1;
            end
            S_F2: begin
                c.mdr_out = 1'b1;
                c.ir_in   = 1'b1;
            end
            S_A0: begin
                c.grb    = 1'b1;
                c.ba_out = 1'b1;
                c.y_in   = 1'b1;
            end
            S_A1: begin
                c.csign_out = 1'b1;
                c.add       = 1'b1;
                c.zlow_in   = 1'b1;
            end
            S_A2: begin
                c.zlow_out = 1'b1;
                c.gra      = 1'b1;
                c.r_in     = 1'b1;
            end
            S_B0: begin
                c.gra    = 1'b1;
                c.r_out  = 1'b1;
                c.con_in = 1'b1;
            end
            S_B1: begin
                c.pc_out = 1'b1;
                c.y_in   = 1'b1;
            end
            S_B2: begin
                c.csign_out = 1'b1;
                c.branch    = 1'b1;
                c.zlow_in   = 1'b1;
            end
            S_B3: begin
                c.zlow_out   = 1'b1;
                c.pc_in_cond = 1'b1;
            end
            S_HALT:  c.run = 1'b0;
            default: c.run = 1'b1;
        endcase
        return c;
    endfunction

    // Undefined opcodes fall through to F0 so they behave as nop.
    always_comb begin
        state_n = state;
        case (state)
            S_RESET: state_n = S_F0;
            S_F0:    state_n = S_F1;
            S_F1:    state_n = S_F2;
            S_F2:    state_n = S_DEC;
            S_DEC: begin
                case (bus.IR[31:27])
                    OP_LDI, OP_ADDI: state_n = S_A0;
                    OP_BR:           state_n = S_B0;
                    OP_HALT:         state_n = S_HALT;
                    OP_NOP:          state_n = S_F0;
                    default:         state_n = S_F0;
                endcase
            end
            S_A0:    state_n = S_A1;
            S_A1:    state_n = S_A2;
            S_A2:    state_n = S_F0;
            S_B0:    state_n = S_B1;
            S_B1:    state_n = S_B2;
            S_B2:    state_n = S_B3;
            S_B3:    state_n = S_F0;
            S_HALT:  state_n = S_HALT;
            default: state_n = S_RESET;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state register.
    always_ff @(posedge clock) begin
        if (clear) begin
            state <= S_RESET;
            ctl   <= decode(S_RESET);
        end else begin
            state <= state_n;
            ctl   <= decode(state_n);
        end
    end

    assign bus.Run      = ctl.run;
    assign bus.PCout    = ctl.pc_out;
    assign bus.Zlowout  = ctl.zlow_out;
    assign bus.MDRout   = ctl.mdr_out;
    assign bus.Rout     = ctl.r_out;
    assign bus.BAout    = ctl.ba_out;
    assign bus.Csignout = ctl.csign_out;
    // Branch target is loaded only when the condition flip-flop is set during B3.
    assign bus.PCin     = ctl.pc_in | (ctl.pc_in_cond & bus.CONFF);
    assign bus.MARin    = ctl.mar_in;
    assign bus.MDRin    = ctl.mdr_in;
    assign bus.IRin     = ctl.ir_in;
    assign bus.Yin      = ctl.y_in;
    assign bus.Zlowin   = ctl.zlow_in;
    assign bus.Rin      = ctl.r_in;
    assign bus.CONin    = ctl.con_in;
    assign bus.IncPC    = ctl.inc_pc;
    assign bus.ADD      = ctl.add;
    assign bus.BRANCH   = ctl.branch;
    assign bus.Read     = ctl.read;
    assign bus.MD_read  = ctl.md_read;
    assign bus.Write    = 1'b0;
    assign bus.Gra      = ctl.gra;
    assign bus.Grb      = ctl.grb;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer
module tb_control_sequencer;

    typedef enum int {
        T_RESET, T_F0, T_F1, T_F2, T_DEC,
        T_A0, T_A1, T_A2,
        T_B0, T_B1, T_B2, T_B3,
        T_HALT
    } st_t;

    typedef struct packed {
        logic run, pc_out, zlow_out, mdr_out, r_out, ba_out, csign_out;
        logic pc_in, mar_in, mdr_in, ir_in, y_in, zlow_in, r_in, con_in;
        logic inc_pc, add, branch, read, md_read, write, gra, grb;
    } vec_t;

    logic clock = 1'b0;
    logic clear;
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;
    vec_t expq[$];

    always #5 clock = ~clock;

    control_sequencer_if bus();

    control_sequencer dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    function automatic vec_t exp_vec(input st_t s, input logic c);
        vec_t v;
        v     = '0;
        v.run = 1'b1;
        case (s)
            T_F0:   begin v.pc_out = 1; v.mar_in = 1; v.inc_pc = 1; v.zlow_in = 1; end
            T_F1:   begin v.zlow_out = 1; v.pc_in = 1; v.read = 1; v.md_read = 1; v.mdr_in = 1; end
            T_F2:   begin v.mdr_out = 1; v.ir_in = 1; end
            T_A0:   begin v.grb = 1; v.ba_out = 1; v.y_in = 1; end
            T_A1:   begin v.csign_out = 1; v.add = 1; v.zlow_in = 1; end
            T_A2:   begin v.zlow_out = 1; v.gra = 1; v.r_in = 1; end
            T_B0:   begin v.gra = 1; v.r_out = 1; v.con_in = 1; end
            T_B1:   begin v.pc_out = 1; v.y_in = 1; end
            T_B2:   begin v.csign_out = 1; v.branch = 1; v.zlow_in = 1; end
            T_B3:   begin v.zlow_out = 1; v.pc_in = c; end
            T_HALT: v.run = 0;
            default: v.run = 1;
        endcase
        return v;
    endfunction

    function automatic vec_t observe();
        vec_t v;
        v = {bus.Run, bus.PCout, bus.Zlowout, bus.MDRout, bus.Rout, bus.BAout, bus.Csignout,
             bus.PCin, bus.MARin, bus.MDRin, bus.IRin, bus.Yin, bus.Zlowin, bus.Rin, bus.CONin,
             bus.IncPC, bus.ADD, bus.BRANCH, bus.Read, bus.MD_read, bus.Write, bus.Gra, bus.Grb};
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_now(input string tag);
        vec_t obs;
        vec_t e;
        int   drivers;
        obs = observe();
        n_total++;
        if (expq.size() == 0) begin
            n_fail++;
            $error("FAIL %s scoreboard empty observed=%h", tag, obs);
        end else begin
            e = expq.pop_front();
            assert (obs === e) n_pass++;
            else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
        drivers = $countones({bus.PCout, bus.Zlowout, bus.MDRout, bus.Rout, bus.BAout, bus.Csignout});
        n_total++;
        assert (drivers <= 1) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s_bus_excl observed=%0d expected<=1", tag, drivers);
        end
    endtask

    // Drives one instruction starting with the DUT showing F0 and ends at the following F0.
    task automatic run_instr(input logic [31:0] ir, input logic c, input bit abort, input string tag);
        st_t  seq[$];
        logic [4:0] op;
        op  = ir[31:27];
        seq = '{T_F0, T_F1, T_F2, T_DEC};
        case (op)
            5'b00001, 5'b01100: begin seq.push_back(T_A0); seq.push_back(T_A1); seq.push_back(T_A2); end
            5'b10010: begin
                seq.push_back(T_B0); seq.push_back(T_B1); seq.push_back(T_B2);
                if (!abort) seq.push_back(T_B3);
            end
            5'b11010: for (int k = 0; k < 20; k++) seq.push_back(T_HALT);
            default: ;
        endcase
        foreach (seq[i]) expq.push_back(exp_vec(seq[i], c));
        bus.IR    = ir;
        bus.CONFF = ~c;
        foreach (seq[i]) begin
            if (seq[i] == T_B3) begin
                bus.CONFF = c;
                #1;
            end
            check_now($sformatf("%s_%s", tag, seq[i].name()));
            if (seq[i] == T_B3) bus.CONFF = ~c;
            if (abort && seq[i] == T_B2) begin
                clear = 1'b1;
                tick();
                clear = 1'b0;
                expq.push_back(exp_vec(T_RESET, 1'b0));
                check_now({tag, "_midop_reset"});
                tick();
                return;
            end
            tick();
            if (seq[i] == T_DEC) bus.IR = $urandom;
        end
    endtask

    initial begin
        logic [4:0] op;
        logic       c;
        clear     = 1'b1;
        bus.IR    = 32'h0;
        bus.CONFF = 1'b0;
        tick();
        tick();
        expq.push_back(exp_vec(T_RESET, 1'b0));
        check_now("reset_held");
        clear = 1'b0;
        expq.push_back(exp_vec(T_RESET, 1'b0));
        check_now("reset_cycle1");
        tick();

        run_instr(32'h6118_0005, 1'b0, 1'b0, "addi");
        run_instr({5'b00001, 27'h0123456}, 1'b0, 1'b0, "ldi");
        run_instr({5'b10010, 27'h0000042}, 1'b1, 1'b0, "br_taken");
        run_instr({5'b10010, 27'h0000042}, 1'b0, 1'b0, "br_not_taken");
        run_instr({5'b11001, 27'h0}, 1'b0, 1'b0, "nop");
        run_instr({5'b11111, 27'h7ffffff}, 1'b0, 1'b0, "undef");
        run_instr({5'b10010, 27'h0000011}, 1'b1, 1'b1, "br_abort");
        run_instr({5'b10010, 27'h0000011}, 1'b1, 1'b0, "br_after_abort");

        run_instr({5'b11010, 27'h0}, 1'b0, 1'b0, "halt");
        clear = 1'b1;
        tick();
        clear = 1'b0;
        expq.push_back(exp_vec(T_RESET, 1'b0));
        check_now("halt_clear");
        tick();

        for (int n = 0; n < 50; n++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'b11010) op = 5'b11001;
            c  = 1'($urandom_range(0, 1));
            run_instr({op, 27'($urandom)}, c, 1'b0, $sformatf("rand%0d", n));
        end

        expq.push_back(exp_vec(T_F0, 1'b0));
        check_now("final_f0");

        n_total++;
        assert (expq.size() == 0) n_pass++;
        else begin
            n_fail++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", expq.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired Moore control unit that drives the one-bus datapath's register-transfer strobes. It sits directly upstream of `DataPath` and replaces the hand-sequenced stimulus currently used to exercise it. It steps through instruction fetch, decodes the opcode in `IR`, runs the execute micro-steps for `ldi`, `addi`, `br`, `nop` and `halt`, and samples `CONFF` to resolve branches. One micro-step takes exactly one clock cycle.

## Interface
Parameters:
- `OP_LDI`, 5'b00001, ldi opcode
- `OP_ADDI`, 5'b01100, addi opcode
- `OP_BR`, 5'b10010, branch opcode (condition in C2 field, evaluated by datapath CON logic)
- `OP_NOP`, 5'b11001, nop opcode
- `OP_HALT`, 5'b11010, halt opcode

Ports:
- `clock` in 1: single system clock; all state changes on the rising edge
- `clear` in 1: synchronous, active-high reset
- `IR` in 32: instruction register contents from datapath; opcode = `IR[31:27]`
- `CONFF` in 1: branch-condition flip-flop from datapath
- `Run` out 1: 1 while executing, 0 in HALT
- `PCout`, `Zlowout`, `MDRout`, `Rout`, `BAout`, `Csignout` out 1 each: bus-drive strobes
- `PCin`, `MARin`, `MDRin`, `IRin`, `Yin`, `Zlowin`, `Rin`, `CONin` out 1 each: register-load strobes
- `IncPC`, `ADD`, `BRANCH` out 1 each: ALU operation selects
- `Read`, `MD_read`, `Write` out 1 each: memory controls (`Write` is constant 0 in this revision)
- `Gra`, `Grb` out 1 each: register-field selects

## Operation
- State register holds one of: RESET, F0, F1, F2, DEC, A0, A1, A2, B0, B1, B2, B3, HALT.
- Outputs are a pure decode of the state register (Moore). In each state, every strobe not listed below is 0.
- RESET: all strobes 0, `Run`=1. Next state F0.
- F0: `PCout`, `MARin`, `IncPC`, `Zlowin`. Next F1.
- F1: `Zlowout`, `PCin`, `Read`, `MD_read`, `MDRin`. Next F2.
- F2: `MDRout`, `IRin`. Next DEC. `IR` is valid from DEC onward.
- DEC: all strobes 0. Next state is chosen from `IR[31:27]`:
  - `OP_LDI` or `OP_ADDI` → A0
  - `OP_BR` → B0
  - `OP_HALT` → HALT
  - `OP_NOP` or any other opcode → F0 (undefined opcodes execute as nop)
- A0: `Grb`, `BAout`, `Yin`. For ldi, Rb=R0, so `BAout` places 0 on the bus.
- A1: `Csignout`, `ADD`, `Zlowin`.
- A2: `Zlowout`, `Gra`, `Rin`. Next F0.
- B0: `Gra`, `Rout`, `CONin`.
- B1: `PCout`, `Yin`.
- B2: `Csignout`, `BRANCH`, `Zlowin`.
- B3: `Zlowout`, and `PCin` = `CONFF`. `PCin` is combinational from `CONFF` in this state only. Next F0.
- HALT: all strobes 0, `Run`=0. The sequencer stays in HALT until `clear`.

## Timing
- `clear`=1 at a rising edge forces RESET on that edge, from any state including mid-fetch, mid-execute and HALT. While `clear` is held, the sequencer stays in RESET.
- Reset values: all strobes 0, `Run`=1.
- First F0 is the cycle after the edge at which `clear` is sampled low.
- Per-instruction cycle counts, from F0 to the next F0:
  - nop/undefined: 4
  - ldi/addi: 7
  - br: 8, whether taken or not
- `CONFF` is sampled only during B3. It is set by `CONin` in B0 and is stable by B3. `CONFF` changes in any other state have no effect.
- At most one bus-drive strobe (`PCout`, `Zlowout`, `MDRout`, `Rout`, `BAout`, `Csignout`) is 1 in any cycle.
- `IR` changes outside DEC do not affect sequencing.

## Test plan
- Reset: hold `clear`=1 for 2 cycles, then release → cycle 1 shows all strobes 0 and `Run`=1; the next cycle is F0 with exactly `PCout`, `MARin`, `IncPC`, `Zlowin`=1.
- addi: `IR`=32'h6118_0005 (opcode 01100) presented from F2 → strobe sequence F0,F1,F2,DEC,A0,A1,A2,F0. `Rin` is 1 only in the cycle at F0+6.
- Branch taken and not taken: `IR` opcode 10010 with `CONFF`=1 in B3 → `PCin`=1 together with `Zlowout` in B3. Repeat with `CONFF`=0 → `PCin`=0 in B3. Both cases return to F0 after 8 cycles.
- Halt and undefined: opcode 11010 → `Run` falls after DEC and stays 0 for 20 cycles; `clear` then restores `Run`=1. Separately, opcode 11111 → DEC goes straight back to F0 (4-cycle loop).
- Mid-op reset: assert `clear` during B2 → next cycle is RESET with all strobes 0; `BRANCH` must not be seen again until a new B2.
- Bus exclusivity: run 50 random opcodes and assert every cycle that at most one bus-drive strobe is high.
